seg7_bcd_display: RTL



---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_bcd_display_if.sv | 30 +++
 rtl/bin2bcd_seq.sv | 99 +++++++++
 rtl/seg7_bcd_display.sv | 128 ++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
// Module      : seg7_pkg
// Description : Segment patterns, decode helper and converter FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_bcd_display_if.sv
// ============================================================================
// Module      : seg7_bcd_display_if
// Description : Load/value request and display pin bundle of seg7_bcd_display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg7_bcd_display_if #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 8
);
    logic [DATA_W-1:0] value;
    logic              load;
    logic              busy;
    logic              overflow;
    logic [7:0]        seg_out;
    logic [DIGITS-1:0] an_out;

    modport master (
        output value, load,
        input  busy, overflow, seg_out, an_out
    );

    modport slave (
        input  value, load,
        output busy, overflow, seg_out, an_out
    );
endinterface

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble binary to BCD, one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = 8
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    conv_state_t        r_state, w_state_nxt;
    logic [DATA_W-1:0]  r_bin, w_bin_nxt;
    logic [BCD_W-1:0]   r_bcd, w_bcd_nxt, w_bcd_adj;
    logic               r_acc, w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bin   <= w_bin_nxt;
            r_bcd   <= w_bcd_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Add-3 correction so each nibble carries into the next one on the shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        w_bcd_nxt   = r_bcd;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_bin_nxt   = bin;
                    w_bcd_nxt   = '0;
                    w_acc_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_bcd_nxt = {w_bcd_adj[BCD_W-2:0], r_bin[DATA_W-1]};
                w_bin_nxt = {r_bin[DATA_W-2:0], 1'b0};
                // A digit carried past the top nibble means the value does not fit
                w_acc_nxt = r_acc | w_bcd_adj[BCD_W-1];
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(DATA_W - 1))
                    w_state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_LATCH);
    assign bcd  = r_bcd;
    assign ovf  = r_acc;

endmodule

`default_nettype wire

// File: rtl/seg7_bcd_display.sv
// ============================================================================
// Module      : seg7_bcd_display
// Description : Binary-to-BCD multiplexed seven-segment driver; optional
//               leading-zero blanking enabled by SEG7_LZ_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_bcd_display
    import seg7_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic               clock,
    input  logic               rst,
    seg7_bcd_display_if.slave  bus
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                  w_conv_busy;
    logic                  w_conv_done;
    logic [4*DIGITS-1:0]   w_conv_bcd;
    logic                  w_conv_ovf;

    logic [4*DIGITS-1:0]   r_disp;
    logic                  r_overflow;
    logic [SCAN_W-1:0]     r_scan_cnt;
    logic [IDX_W-1:0]      r_digit_idx;
    logic [DIGITS-1:0]     r_an;
    logic [7:0]            r_seg;
    logic [DIGITS-1:0]     w_blank;
    logic [3:0]            w_nibble;
    logic [6:0]            w_seg_pat;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clock (clock),
        .rst   (rst),
        .start (bus.load),
        .bin   (bus.value),
        .busy  (w_conv_busy),
        .done  (w_conv_done),
        .bcd   (w_conv_bcd),
        .ovf   (w_conv_ovf)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_disp     <= '0;
            r_overflow <= 1'b0;
        end else if (w_conv_done) begin
            r_disp     <= w_conv_bcd;
            r_overflow <= w_conv_ovf;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
        end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= (r_digit_idx == IDX_W'(DIGITS - 1)) ? '0
                                                               : r_digit_idx + IDX_W'(1);
        end else begin
            r_scan_cnt  <= r_scan_cnt + SCAN_W'(1);
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    // A digit is blank when it and every digit above it are zero; digit 0 always shows
    always_comb begin : lz_scan
        logic zero_run;
        zero_run = 1'b1;
        w_blank  = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run & (r_disp[4*i +: 4] == 4'd0);
            w_blank[i] = zero_run;
        end
    end
`else
    assign w_blank = '0;
`endif

    always_comb begin
        w_nibble = r_disp[4*r_digit_idx +: 4];
        if (r_overflow)
            w_seg_pat = SEG_DASH;
        else if (w_blank[r_digit_idx])
            w_seg_pat = SEG_BLANK;
        else
            w_seg_pat = seg_decode(w_nibble);
    end

    // Anode and segments register together so the pair always switches in step
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_an  <= '0;
            r_seg <= '0;
        end else begin
            r_an  <= DIGITS'(1) << r_digit_idx;
            r_seg <= {1'b0, w_seg_pat};
        end
    end

    generate
        if (ACTIVE_LOW != 0) begin : g_active_low
            assign bus.an_out  = ~r_an;
            assign bus.seg_out = ~r_seg;
        end else begin : g_active_high
            assign bus.an_out  = r_an;
            assign bus.seg_out = r_seg;
        end
    endgenerate

    assign bus.busy     = w_conv_busy;
    assign bus.overflow = r_overflow;

endmodule

`default_nettype wire
